// File: rtl/i2c_target_responder_pkg.sv
// rtl/i2c_target_responder_pkg.sv - shared types and widths for the i2c target responder
package i2c_pkg;

    localparam int I2C_ADDR_W = 7;
    localparam int I2C_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        IGNORE
    } i2c_tgt_state_e;

    // Address byte on the wire is {addr[6:0], r_w}
    function automatic logic [I2C_ADDR_W-1:0] addr_of(input logic [I2C_BYTE_W-1:0] b);
        return b[I2C_BYTE_W-1:1];
    endfunction

endpackage

// File: rtl/i2c_target_responder_if.sv
// rtl/i2c_target_responder_if.sv - i2c line, byte stream and debug signals of the target responder
interface i2c_target_responder_if;
    import i2c_pkg::*;

    logic                  scl_i;
    logic                  sda_i;
    logic                  sda_oe;
    logic [I2C_BYTE_W-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [I2C_BYTE_W-1:0] tx_data;
    logic                  tx_req;
    logic                  busy;
    logic [2:0]            dbg_bit_cnt;

    modport master (
        output scl_i, sda_i, rx_ready, tx_data,
        input  sda_oe, rx_data, rx_valid, tx_req, busy, dbg_bit_cnt
    );

    modport slave (
        input  scl_i, sda_i, rx_ready, tx_data,
        output sda_oe, rx_data, rx_valid, tx_req, busy, dbg_bit_cnt
    );

endinterface

// File: rtl/i2c_target_responder_line_sync.sv
// rtl/i2c_target_responder_line_sync.sv - scl/sda synchronizers with edge and START/STOP pulses
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic PCLK,
    input  logic PRESET,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_lvl
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_s;
    logic                   sda_s;
    logic                   scl_d;
    logic                   sda_d;

    assign scl_s = scl_sync[SYNC_STAGES-1];
    assign sda_s = sda_sync[SYNC_STAGES-1];

    // Lines idle high, so the chain resets to 1 to avoid a phantom edge
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_d    <= 1'b1;
            sda_d    <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
            scl_d    <= scl_s;
            sda_d    <= sda_s;
        end
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            scl_rise  <= 1'b0;
            scl_fall  <= 1'b0;
            start_det <= 1'b0;
            stop_det  <= 1'b0;
            sda_lvl   <= 1'b1;
        end else begin
            scl_rise  <= scl_s & ~scl_d;
            scl_fall  <= ~scl_s & scl_d;
            start_det <= scl_s & scl_d & sda_d & ~sda_s;
            stop_det  <= scl_s & scl_d & ~sda_d & sda_s;
            sda_lvl   <= sda_s;
        end
    end

endmodule

// File: rtl/i2c_target_responder.sv
// rtl/i2c_target_responder.sv - i2c target: address match, write-byte stream out, read-byte fetch
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter logic [I2C_ADDR_W-1:0] TARGET_ADDR = 7'h55,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    i2c_target_responder_if.slave bus
);

    logic scl_rise, scl_fall, start_det, stop_det, sda_lvl;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .scl_i     (bus.scl_i),
        .sda_i     (bus.sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .start_det (start_det),
        .stop_det  (stop_det),
        .sda_lvl   (sda_lvl)
    );

    i2c_tgt_state_e        state, state_n;
    logic [2:0]            bit_cnt, bit_cnt_n, bit_cnt_dec;
    logic [I2C_BYTE_W-1:0] shreg, shreg_n, rx_byte;
    logic [I2C_BYTE_W-1:0] rx_data, rx_data_n;
    logic                  sda_oe, sda_oe_n;
    logic                  rx_valid, rx_valid_n;
    logic                  tx_req, tx_req_n;
    logic                  busy, busy_n;
    logic                  rw, rw_n;
    logic                  ack_ok, ack_ok_n;
    // phase marks the second half of an ack slot (ack driven, or master ACK seen)
    logic                  phase, phase_n;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            bit_cnt  <= 3'd7;
            shreg    <= '0;
            rx_data  <= '0;
            sda_oe   <= 1'b0;
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            busy     <= 1'b0;
            rw       <= 1'b0;
            ack_ok   <= 1'b0;
            phase    <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            rx_data  <= rx_data_n;
            sda_oe   <= sda_oe_n;
            rx_valid <= rx_valid_n;
            tx_req   <= tx_req_n;
            busy     <= busy_n;
            rw       <= rw_n;
            ack_ok   <= ack_ok_n;
            phase    <= phase_n;
        end
    end

    assign bit_cnt_dec = bit_cnt - 3'd1;
    assign rx_byte     = {shreg[I2C_BYTE_W-2:0], sda_lvl};

    always_comb begin
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        rx_data_n  = rx_data;
        sda_oe_n   = sda_oe;
        rx_valid_n = 1'b0;
        tx_req_n   = 1'b0;
        busy_n     = busy;
        rw_n       = rw;
        ack_ok_n   = ack_ok;
        phase_n    = phase;

        // tx_data is taken in the cycle the request strobe is high
        if (tx_req) begin
            shreg_n = bus.tx_data;
        end

        if (start_det) begin
            state_n   = ADDR;
            bit_cnt_n = 3'd7;
            sda_oe_n  = 1'b0;
            phase_n   = 1'b0;
        end else if (stop_det) begin
            state_n   = IDLE;
            bit_cnt_n = 3'd7;
            sda_oe_n  = 1'b0;
            busy_n    = 1'b0;
            phase_n   = 1'b0;
        end else begin
            case (state)
                ADDR: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt_dec;
                        if (bit_cnt == 3'd0) begin
                            if (addr_of(rx_byte) == TARGET_ADDR) begin
                                state_n  = ADDR_ACK;
                                busy_n   = 1'b1;
                                rw_n     = rx_byte[0];
                                tx_req_n = rx_byte[0];
                            end else begin
                                state_n = IGNORE;
                                busy_n  = 1'b0;
                            end
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_oe_n = 1'b1;
                            phase_n  = 1'b1;
                        end else begin
                            phase_n   = 1'b0;
                            bit_cnt_n = 3'd7;
                            if (rw) begin
                                sda_oe_n = ~shreg[7];
                                state_n  = RD_DATA;
                            end else begin
                                sda_oe_n = 1'b0;
                                state_n  = WR_DATA;
                            end
                        end
                    end
                end
                WR_DATA: begin
                    if (scl_rise) begin
                        shreg_n   = rx_byte;
                        bit_cnt_n = bit_cnt_dec;
                        if (bit_cnt == 3'd0) begin
                            ack_ok_n = bus.rx_ready;
                            state_n  = WR_ACK;
                            if (bus.rx_ready) begin
                                rx_data_n  = rx_byte;
                                rx_valid_n = 1'b1;
                            end
                        end
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        if (!phase) begin
                            sda_oe_n = ack_ok;
                            phase_n  = 1'b1;
                        end else begin
                            sda_oe_n  = 1'b0;
                            phase_n   = 1'b0;
                            bit_cnt_n = 3'd7;
                            state_n   = WR_DATA;
                        end
                    end
                end
                RD_DATA: begin
                    if (scl_fall) begin
                        if (bit_cnt == 3'd0) begin
                            sda_oe_n  = 1'b0;
                            bit_cnt_n = 3'd7;
                            state_n   = RD_ACK;
                        end else begin
                            sda_oe_n  = ~shreg[bit_cnt_dec];
                            bit_cnt_n = bit_cnt_dec;
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise && !phase) begin
                        if (!sda_lvl) begin
                            tx_req_n = 1'b1;
                            phase_n  = 1'b1;
                        end else begin
                            state_n = IGNORE;
                        end
                    end else if (scl_fall && phase) begin
                        sda_oe_n  = ~shreg[7];
                        phase_n   = 1'b0;
                        bit_cnt_n = 3'd7;
                        state_n   = RD_DATA;
                    end
                end
                IGNORE: begin
                    sda_oe_n = 1'b0;
                end
                default: begin
                    sda_oe_n = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe      = sda_oe;
    assign bus.rx_data     = rx_data;
    assign bus.rx_valid    = rx_valid;
    assign bus.tx_req      = tx_req;
    assign bus.busy        = busy;
    assign bus.dbg_bit_cnt = bit_cnt;

endmodule

// File: tb/tb_i2c_target_responder.sv
// tb/tb_i2c_target_responder.sv - scoreboard bench driving i2c master transfers into the target
module tb_i2c_target_responder;

    logic PCLK = 1'b0;
    logic PRESET;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    always #5 PCLK = ~PCLK;

    i2c_target_responder_if bus();

    assign bus.scl_i = scl_m;
    assign bus.sda_i = sda_m & ~bus.sda_oe;

    i2c_target_responder #(.TARGET_ADDR(7'h55), .SYNC_STAGES(2)) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_q[$];
    int         txreq_q[$];
    logic       bit_q[$];
    logic       tgt_slot = 1'b0;
    logic       quiet = 1'b0;
    logic       oe_seen = 1'b0;
    logic       busy_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge PCLK) begin
        if (PRESET === 1'b0) begin
            if (bus.rx_valid) begin
                if (rx_q.size() == 0) chk("rx_valid_unexpected", 1, 0);
                else chk("rx_data", bus.rx_data, rx_q.pop_front());
            end
            if (bus.tx_req) begin
                if (txreq_q.size() == 0) chk("tx_req_unexpected", 1, 0);
                else chk("tx_req_token", 1, (txreq_q.pop_front() > 0) ? 1 : 0);
            end
            if (quiet) begin
                if (bus.sda_oe) oe_seen = 1'b1;
                if (bus.busy) busy_seen = 1'b1;
            end
        end
    end

    always @(posedge scl_m) begin
        if (tgt_slot) begin
            #25;
            if (bit_q.size() == 0) chk("sda_bit_unexpected", 1, 0);
            else chk("sda_bit", bus.sda_i, bit_q.pop_front());
        end
    end

    task automatic clk_bit(input logic b);
        sda_m = b;
        #50 scl_m = 1'b1;
        #100 scl_m = 1'b0;
        #50;
    endtask

    task automatic start_c();
        sda_m = 1'b1;
        #50 scl_m = 1'b1;
        #50 sda_m = 1'b0;
        #50 scl_m = 1'b0;
        #50;
    endtask

    task automatic stop_c();
        scl_m = 1'b0;
        sda_m = 1'b0;
        #50 scl_m = 1'b1;
        #50 sda_m = 1'b1;
        #100;
    endtask

    task automatic target_bit(input logic exp);
        bit_q.push_back(exp);
        tgt_slot = 1'b1;
        clk_bit(1'b1);
        tgt_slot = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic exp_ack);
        for (int i = 7; i >= 0; i--) clk_bit(d[i]);
        target_bit(exp_ack);
    endtask

    task automatic recv_byte(input logic [7:0] exp, input logic mack);
        for (int i = 7; i >= 0; i--) target_bit(exp[i]);
        clk_bit(mack);
    endtask

    initial begin
        PRESET = 1'b1;
        bus.rx_ready = 1'b1;
        bus.tx_data = 8'h00;
        #23;
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_tx_req", bus.tx_req, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_bit_cnt", bus.dbg_bit_cnt, 7);
        @(negedge PCLK);
        PRESET = 1'b0;
        #200;

        // write 0xA5 to 0x55
        rx_q.push_back(8'hA5);
        start_c();
        send_byte(8'hAA, 1'b0);
        chk("wr_busy", bus.busy, 1);
        send_byte(8'hA5, 1'b0);
        stop_c();
        chk("wr_busy_after_stop", bus.busy, 0);

        // read 0x3C, master NACK
        bus.tx_data = 8'h3C;
        txreq_q.push_back(1);
        start_c();
        send_byte(8'hAB, 1'b0);
        recv_byte(8'h3C, 1'b1);
        #100;
        chk("rd_nack_released", bus.sda_oe, 0);
        stop_c();

        // address mismatch
        quiet = 1'b1;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        start_c();
        send_byte(8'h24, 1'b1);
        send_byte(8'hFF, 1'b1);
        stop_c();
        quiet = 1'b0;
        chk("mismatch_sda_oe", oe_seen, 0);
        chk("mismatch_busy", busy_seen, 0);

        // write with sink not ready
        bus.rx_ready = 1'b0;
        start_c();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h5A, 1'b1);
        stop_c();
        chk("nack_rx_data_kept", bus.rx_data, 8'hA5);
        bus.rx_ready = 1'b1;

        // two-byte read
        bus.tx_data = 8'h81;
        txreq_q.push_back(1);
        txreq_q.push_back(1);
        start_c();
        send_byte(8'hAB, 1'b0);
        for (int i = 7; i >= 0; i--) target_bit(bus.tx_data[i]);
        bus.tx_data = 8'h7E;
        clk_bit(1'b0);
        recv_byte(8'h7E, 1'b1);
        stop_c();

        // STOP in the middle of a read byte, then a fresh write
        bus.tx_data = 8'h3C;
        txreq_q.push_back(1);
        start_c();
        send_byte(8'hAB, 1'b0);
        target_bit(1'b0);
        target_bit(1'b0);
        target_bit(1'b1);
        stop_c();
        chk("stop_sda_oe", bus.sda_oe, 0);
        chk("stop_busy", bus.busy, 0);
        chk("stop_bit_cnt", bus.dbg_bit_cnt, 7);
        rx_q.push_back(8'h11);
        start_c();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h11, 1'b0);
        stop_c();

        // PRESET in the middle of a read byte while the target pulls sda low
        txreq_q.push_back(1);
        start_c();
        send_byte(8'hAB, 1'b0);
        target_bit(1'b0);
        chk("pre_reset_sda_oe", bus.sda_oe, 1);
        @(negedge PCLK);
        #2 PRESET = 1'b1;
        #1;
        chk("reset_sda_oe_async", bus.sda_oe, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_bit_cnt", bus.dbg_bit_cnt, 7);
        @(negedge PCLK);
        PRESET = 1'b0;
        sda_m = 1'b1;
        #50 scl_m = 1'b1;
        #200;
        rx_q.push_back(8'h22);
        start_c();
        send_byte(8'hAA, 1'b0);
        send_byte(8'h22, 1'b0);
        stop_c();

        #500;
        chk("rx_q_drained", rx_q.size(), 0);
        chk("txreq_q_drained", txreq_q.size(), 0);
        chk("bit_q_drained", bit_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
